// File: rtl/decoder_nx2n_seq_if.sv
// Select/strobe bundle for the N-to-2^N sequenced decoder.
// The master drives the controls and the slave returns the registered decode.
interface decoder_nx2n_seq_if #(
   parameter int N = 2
);
   logic               en;
   logic               mode;
   logic [N-1:0]       in;
   logic               load;
   logic [(1<<N)-1:0]  out;
   logic [N-1:0]       idx;
   logic               valid;
   logic               wrap;

   modport master (
      output en, mode, in, load,
      input  out, idx, valid, wrap
   );

   modport slave (
      input  en, mode, in, load,
      output out, idx, valid, wrap
   );
endinterface

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with a direct mode and a self-running scan mode.
// In scan mode each index is held for DWELL cycles before the next one is shown.
module decoder_nx2n_seq #(
   parameter int N          = 2,
   parameter int DWELL      = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   decoder_nx2n_seq_if.slave  bus
);
   localparam int            W        = 1 << N;
   localparam logic [W-1:0]  OUT_OFF  = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};
   localparam logic [15:0]   CNT_LAST = 16'(DWELL - 1);
   localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [N-1:0]  idx_r, idx_s;
   logic [15:0]   cnt_r, cnt_s;
   logic          valid_r, valid_s;
   logic          wrap_r, wrap_s;
   logic [W-1:0]  out_r, out_s;

   function automatic logic [W-1:0] decode(input logic [N-1:0] sel);
      logic [W-1:0] hot;
      hot = {{(W-1){1'b0}}, 1'b1} << sel;
      return ACTIVE_LOW ? ~hot : hot;
   endfunction

   // Next-state, index, dwell counter and output decode.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      cnt_s   = cnt_r;
      valid_s = valid_r;
      wrap_s  = 1'b0;
      if (!bus.en) begin
         state_s = IDLE;
         idx_s   = {N{1'b0}};
         cnt_s   = 16'd0;
         valid_s = 1'b0;
      end else if (!bus.mode) begin
         state_s = DIRECT;
         idx_s   = bus.in;
         cnt_s   = 16'd0;
         valid_s = 1'b1;
      end else if ((state_r != SCAN) || bus.load) begin
         // Scan entry and reload share one path; a reload never raises wrap.
         state_s = SCAN;
         idx_s   = bus.in;
         cnt_s   = 16'd0;
         valid_s = 1'b1;
      end else if (cnt_r == CNT_LAST) begin
         cnt_s   = 16'd0;
         idx_s   = idx_r + 1'b1;
         wrap_s  = (idx_r == IDX_LAST);
      end else begin
         cnt_s   = cnt_r + 16'd1;
      end
      out_s = valid_s ? decode(idx_s) : OUT_OFF;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         idx_r   <= {N{1'b0}};
         cnt_r   <= 16'd0;
         valid_r <= 1'b0;
         wrap_r  <= 1'b0;
         out_r   <= OUT_OFF;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         cnt_r   <= cnt_s;
         valid_r <= valid_s;
         wrap_r  <= wrap_s;
         out_r   <= out_s;
      end
   end

   assign bus.out   = out_r;
   assign bus.idx   = idx_r;
   assign bus.valid = valid_r;
   assign bus.wrap  = wrap_r;
endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Randomised and directed bench for decoder_nx2n_seq against a cycle-level reference model.
// A second instance covers the inverted-polarity, 3-bit configuration.
module tb_decoder_nx2n_seq;
   localparam int DW = 3;

   logic clk;
   logic rst;
   int   test_cnt;
   int   fail_cnt;

   // reference model of the N=2, DWELL=3 instance
   bit   m_act;
   bit   m_scan;
   bit   m_wrap;
   int   m_idx;
   int   m_held;

   decoder_nx2n_seq_if #(.N(2)) bus ();
   decoder_nx2n_seq_if #(.N(3)) bus3 ();

   decoder_nx2n_seq #(.N(2), .DWELL(DW), .ACTIVE_LOW(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   decoder_nx2n_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      test_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_act  = 1'b0;
      m_scan = 1'b0;
      m_wrap = 1'b0;
      m_idx  = 0;
      m_held = 0;
   endtask

   task automatic model_tick(input bit e, input bit m, input int i, input bit l);
      m_wrap = 1'b0;
      if (!e) begin
         model_reset();
      end else if (!m) begin
         m_act  = 1'b1;
         m_scan = 1'b0;
         m_idx  = i;
         m_held = 0;
      end else if (!m_scan || l) begin
         m_act  = 1'b1;
         m_scan = 1'b1;
         m_idx  = i;
         m_held = 0;
      end else if (m_held == DW - 1) begin
         m_held = 0;
         m_idx  = (m_idx + 1) % 4;
         m_wrap = (m_idx == 0);
      end else begin
         m_held++;
      end
   endtask

   task automatic check_model(input string tag);
      int exp_out;
      exp_out = m_act ? (1 << m_idx) : 0;
      check_val({tag, ".out"},   32'(bus.out),   32'(exp_out));
      check_val({tag, ".idx"},   32'(bus.idx),   32'(m_idx));
      check_val({tag, ".valid"}, 32'(bus.valid), 32'(m_act));
      check_val({tag, ".wrap"},  32'(bus.wrap),  32'(m_wrap));
   endtask

   // drive at the falling edge, clock once, check at the next falling edge
   task automatic step(input string tag, input bit e, input bit m, input int i, input bit l);
      bus.en   = e;
      bus.mode = m;
      bus.in   = 2'(i);
      bus.load = l;
      @(posedge clk);
      model_tick(e, m, i, l);
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      int wraps;
      clk      = 1'b0;
      rst      = 1'b1;
      test_cnt = 0;
      fail_cnt = 0;
      bus.en   = 1'b0;
      bus.mode = 1'b0;
      bus.in   = 2'd0;
      bus.load = 1'b0;
      bus3.en   = 1'b0;
      bus3.mode = 1'b0;
      bus3.in   = 3'd0;
      bus3.load = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_model("reset");
      check_val("reset3.out", 32'(bus3.out), 32'h0000_00ff);
      rst = 1'b0;

      step("idle_hold", 1'b0, 1'b1, 3, 1'b0);

      for (int v = 0; v < 4; v++) begin
         step("direct", 1'b1, 1'b0, v, 1'b0);
         check_val("direct_onehot", 32'(bus.out), 32'(1 << v));
      end

      step("scan_entry", 1'b1, 1'b1, 2, 1'b0);
      wraps = 0;
      for (int c = 0; c < 9; c++) begin
         step("scan", 1'b1, 1'b1, 1, 1'b0);
         if (bus.wrap) wraps++;
      end
      check_val("scan_wrap_count", 32'(wraps), 32'd1);

      step("pre_load", 1'b1, 1'b0, 0, 1'b0);
      step("load_entry", 1'b1, 1'b1, 2, 1'b0);
      step("load_cnt1", 1'b1, 1'b1, 0, 1'b0);
      step("load_cnt2", 1'b1, 1'b1, 0, 1'b0);
      step("load_prio", 1'b1, 1'b1, 1, 1'b1);
      check_val("load_idx", 32'(bus.idx), 32'd1);
      for (int c = 0; c < 3; c++) step("load_dwell", 1'b1, 1'b1, 0, 1'b0);
      check_val("load_advance", 32'(bus.idx), 32'd2);

      step("load_zero", 1'b1, 1'b1, 0, 1'b1);
      check_val("load_zero_wrap", 32'(bus.wrap), 32'd0);

      step("en_drop", 1'b0, 1'b1, 0, 1'b0);
      check_val("en_drop_valid", 32'(bus.valid), 32'd0);
      step("reenable", 1'b1, 1'b0, 3, 1'b0);
      check_val("reenable_out", 32'(bus.out), 32'h8);

      step("midrun_scan", 1'b1, 1'b1, 3, 1'b0);
      step("midrun_scan", 1'b1, 1'b1, 0, 1'b0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_model("async_reset");
      @(negedge clk);
      rst = 1'b0;
      step("post_reset_idle", 1'b0, 1'b1, 2, 1'b0);

      for (int c = 0; c < 400; c++) begin
         step("rand",
              ($urandom_range(0, 11) != 0),
              ($urandom_range(0, 5) != 0) ? bus.mode : ~bus.mode,
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0));
      end

      bus.en = 1'b0;
      for (int v = 0; v < 8; v++) begin
         bus3.en   = 1'b1;
         bus3.mode = 1'b0;
         bus3.in   = 3'(v);
         @(posedge clk);
         @(negedge clk);
         check_val("al_direct", 32'(bus3.out), 32'(8'(~(8'd1 << v))));
         check_val("al_valid",  32'(bus3.valid), 32'd1);
      end
      bus3.en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("al_idle", 32'(bus3.out), 32'h0000_00ff);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end
endmodule
